// File: rtl/rx_reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_reset_sequencer_pkg
// Description : Shared FSM encodings, cause bit indices and a width helper
//               for the RX reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package rx_reset_sequencer_pkg;

    localparam logic [1:0] S_RSEQ_IDLE    = 2'd0;
    localparam logic [1:0] S_RSEQ_ASSERT  = 2'd1;
    localparam logic [1:0] S_RSEQ_HOLDOFF = 2'd2;

    localparam int CAUSE_WD = 0;
    localparam int CAUSE_SW = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_reset_sequencer_sat_event_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_event_counter
// Description : Event counter that saturates at all-ones; clear wins over
//               a same-cycle increment.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_event_counter #(
    parameter int WIDTH = 22
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + c_ONE;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/rx_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rx_reset_sequencer
// Description : Turns watchdog/software abort requests into a fixed-length
//               RX core reset pulse followed by a hold-off window, with
//               issued/suppressed counters and last-cause capture.
//               Optional last-reset timestamp: RX_RST_SEQ_TIMESTAMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_reset_sequencer
    import rx_reset_sequencer_pkg::*;
#(
    parameter int RST_LEN_WIDTH = 8,
    parameter int HOLDOFF_WIDTH = 16,
    parameter int COUNTER_WIDTH = 22
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     enable,
    input  logic                     watchdog_rst_in,
    input  logic                     sw_rst_req,
    input  logic [RST_LEN_WIDTH-1:0] rst_len,
    input  logic [HOLDOFF_WIDTH-1:0] holdoff_len,
    input  logic                     clr_counters,
    output logic                     rx_core_rst,
    output logic                     holdoff_active,
    output logic [1:0]               last_cause,
    output logic [COUNTER_WIDTH-1:0] rst_issued_cnt,
    output logic [COUNTER_WIDTH-1:0] rst_suppressed_cnt,
    output logic [31:0]              last_rst_ts
);

    localparam int c_CNT_W = max_int(RST_LEN_WIDTH, HOLDOFF_WIDTH);
    localparam logic [c_CNT_W-1:0]       c_CNT_ONE = {{(c_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [RST_LEN_WIDTH-1:0] c_RL_ONE  = {{(RST_LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [HOLDOFF_WIDTH-1:0] c_HO_ONE  = {{(HOLDOFF_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]         state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               wd_prev_q;
    logic               rx_core_rst_q, rx_core_rst_d;
    logic               holdoff_active_q, holdoff_active_d;
    logic [1:0]         last_cause_q, last_cause_d;

    logic               w_trig_wd;
    logic               w_trig_sw;
    logic               w_wd_edge;
    logic               w_enter_assert;
    logic               w_suppress;
    logic [c_CNT_W-1:0] w_rst_load;
    logic [c_CNT_W-1:0] w_hold_load;

    assign w_trig_wd  = enable & watchdog_rst_in;
    assign w_trig_sw  = enable & sw_rst_req;
    assign w_wd_edge  = w_trig_wd & ~wd_prev_q;
    assign w_suppress = w_wd_edge & (state_q != S_RSEQ_IDLE);

    // A zero length is treated as one cycle, so the load value floors at 0.
    assign w_rst_load  = (rst_len == '0) ? '0 : c_CNT_W'(rst_len - c_RL_ONE);
    assign w_hold_load = c_CNT_W'(holdoff_len - c_HO_ONE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q          <= S_RSEQ_IDLE;
            cnt_q            <= '0;
            wd_prev_q        <= 1'b0;
            rx_core_rst_q    <= 1'b0;
            holdoff_active_q <= 1'b0;
            last_cause_q     <= 2'b00;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            wd_prev_q        <= watchdog_rst_in;
            rx_core_rst_q    <= rx_core_rst_d;
            holdoff_active_q <= holdoff_active_d;
            last_cause_q     <= last_cause_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        w_enter_assert = 1'b0;
        case (state_q)
            S_RSEQ_IDLE: begin
                if (w_trig_wd || w_trig_sw) begin
                    state_d        = S_RSEQ_ASSERT;
                    cnt_d          = w_rst_load;
                    w_enter_assert = 1'b1;
                end
            end
            S_RSEQ_ASSERT: begin
                if (cnt_q == '0) begin
                    if (holdoff_len == '0) begin
                        state_d = S_RSEQ_IDLE;
                    end else begin
                        state_d = S_RSEQ_HOLDOFF;
                        cnt_d   = w_hold_load;
                    end
                end else begin
                    cnt_d = cnt_q - c_CNT_ONE;
                end
            end
            S_RSEQ_HOLDOFF: begin
                // Software requests bypass the hold-off; watchdog ones wait.
                if (w_trig_sw) begin
                    state_d        = S_RSEQ_ASSERT;
                    cnt_d          = w_rst_load;
                    w_enter_assert = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = S_RSEQ_IDLE;
                end else begin
                    cnt_d = cnt_q - c_CNT_ONE;
                end
            end
            default: begin
                state_d = S_RSEQ_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        rx_core_rst_d    = (state_d == S_RSEQ_ASSERT);
        holdoff_active_d = (state_d == S_RSEQ_HOLDOFF);
        last_cause_d     = last_cause_q;
        if (clr_counters) begin
            last_cause_d = 2'b00;
        end else if (w_enter_assert) begin
            last_cause_d[CAUSE_WD] = w_trig_wd;
            last_cause_d[CAUSE_SW] = w_trig_sw;
        end
    end

    sat_event_counter #(
        .WIDTH (COUNTER_WIDTH)
    ) u_issued_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (clr_counters),
        .inc   (w_enter_assert),
        .count (rst_issued_cnt)
    );

    sat_event_counter #(
        .WIDTH (COUNTER_WIDTH)
    ) u_suppressed_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (clr_counters),
        .inc   (w_suppress),
        .count (rst_suppressed_cnt)
    );

`ifdef RX_RST_SEQ_TIMESTAMP_EN
    logic [31:0] ts_q;
    logic [31:0] last_ts_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ts_q      <= '0;
            last_ts_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
            if (clr_counters) begin
                last_ts_q <= '0;
            end else if (w_enter_assert) begin
                last_ts_q <= ts_q;
            end
        end
    end

    assign last_rst_ts = last_ts_q;
`else
    assign last_rst_ts = 32'd0;
`endif

    assign rx_core_rst    = rx_core_rst_q;
    assign holdoff_active = holdoff_active_q;
    assign last_cause     = last_cause_q;

endmodule
`default_nettype wire
